// File: rtl/cpu_pkg.sv
// Shared CPU encodings, datapath widths and the EX/MEM payload layout.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SLT  = 4'h7,
    OP_LW   = 4'h8,
    OP_SW   = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_JMP  = 4'hC,
    OP_MOV  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              writemem;
    logic              readmem;
    logic              regwrite;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
  } ex_mem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational 8-bit ALU; control-flow and no-op codes produce zero.
module ex_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sign,
  output logic [DATA_W-1:0] result
);

  logic slt_bit;

  // Set-less-than in either signed or unsigned interpretation.
  always_comb begin
    slt_bit = sign ? ($signed(a) < $signed(b)) : (a < b);
  end

  // Operation select; arithmetic wraps modulo 2^DATA_W.
  always_comb begin
    result = '0;
    case (opcode_t'(op))
      OP_ADD, OP_LW, OP_SW: result = a + b;
      OP_SUB:               result = a - b;
      OP_AND:               result = a & b;
      OP_OR:                result = a | b;
      OP_XOR:               result = a ^ b;
      OP_SLL:               result = a << b[2:0];
      OP_SRL:               result = a >> b[2:0];
      OP_SLT:               result = DATA_W'(slt_bit);
      OP_MOV:               result = b;
      default:              result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution, HALT FSM and EX/MEM register.
module ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] value,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic              imm_flag,
  input  logic              sign_flag,
  input  logic [DATA_W-1:0] label_value,
  input  logic              writemem,
  input  logic              readmem,
  input  logic              regwrite,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_W-1:0]  rd_out,
  output logic              writemem_out,
  output logic              readmem_out,
  output logic              regwrite_out,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              halted
);

  state_t            state, state_next;
  ex_mem_t           q, d;
  logic              halted_next;
  logic [DATA_W-1:0] fwd_a, fwd_rt, op_b, alu_out;
  logic [OP_W-1:0]   alu_op;
  logic              fwd_ok, is_mem, is_branch, taken;
  opcode_t           op;

  assign op = opcode_t'(opcode);

  // Bypass from EX/MEM when it holds a non-load result for the same nonzero register.
  always_comb begin
    fwd_ok = q.valid && q.regwrite && !q.readmem;
    fwd_a  = (fwd_ok && (q.rd == rs) && (rs != '0)) ? q.alu_result : rs_data;
    fwd_rt = (fwd_ok && (q.rd == rt) && (rt != '0)) ? q.alu_result : rt_data;
  end

  // Operand B and branch decode; loads/stores always add the offset.
  always_comb begin
    is_mem    = (op == OP_LW) || (op == OP_SW);
    is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
    op_b      = (imm_flag || is_mem) ? value : fwd_rt;
    alu_op    = opcode;
    taken     = 1'b0;
    case (op)
      OP_BEQ:  taken = (fwd_a == fwd_rt);
      OP_BNE:  taken = (fwd_a != fwd_rt);
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  ex_alu u_alu (
    .op     (alu_op),
    .a      (fwd_a),
    .b      (op_b),
    .sign   (sign_flag),
    .result (alu_out)
  );

  // Next-state and next EX/MEM contents: flush bubbles, stall holds, else capture.
  always_comb begin
    state_next = state;
    d          = q;
    if (flush) begin
      d.valid    = 1'b0;
      d.writemem = 1'b0;
      d.readmem  = 1'b0;
      d.regwrite = 1'b0;
      d.redirect = 1'b0;
    end else if (!stall) begin
      d.valid    = 1'b0;
      d.writemem = 1'b0;
      d.readmem  = 1'b0;
      d.regwrite = 1'b0;
      d.redirect = 1'b0;
      if ((state == ST_RUN) && in_valid) begin
        if (op == OP_HALT) begin
          state_next = ST_HALTED;
        end else if (op != OP_NOP) begin
          d.valid      = 1'b1;
          d.alu_result = alu_out;
          d.store_data = fwd_rt;
          d.rd         = rd;
          d.writemem   = writemem && !is_branch;
          d.readmem    = readmem && !is_branch;
          d.regwrite   = regwrite && !is_branch && (op != OP_SW);
          d.redirect   = taken;
          if (is_branch) d.redirect_pc = label_value;
        end
      end
    end
    halted_next = (state_next == ST_HALTED);
  end

  // State and EX/MEM register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      q      <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      q      <= d;
      halted <= halted_next;
    end
  end

  assign out_valid    = q.valid;
  assign alu_result   = q.alu_result;
  assign store_data   = q.store_data;
  assign rd_out       = q.rd;
  assign writemem_out = q.writemem;
  assign readmem_out  = q.readmem;
  assign regwrite_out = q.regwrite;
  assign redirect     = q.redirect;
  assign redirect_pc  = q.redirect_pc;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, stall, flush;
  logic [3:0] opcode, rs, rt, rd;
  logic [7:0] value, label_value, rs_data, rt_data;
  logic       imm_flag, sign_flag, writemem, readmem, regwrite;
  logic       out_valid, writemem_out, readmem_out, regwrite_out, redirect, halted;
  logic [7:0] alu_result, store_data, redirect_pc;
  logic [3:0] rd_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .opcode(opcode), .value(value), .rs(rs), .rt(rt), .rd(rd),
    .imm_flag(imm_flag), .sign_flag(sign_flag), .label_value(label_value),
    .writemem(writemem), .readmem(readmem), .regwrite(regwrite),
    .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .alu_result(alu_result), .store_data(store_data),
    .rd_out(rd_out), .writemem_out(writemem_out), .readmem_out(readmem_out),
    .regwrite_out(regwrite_out), .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  task automatic set_instr(input logic [3:0] op_i, input logic [3:0] rs_i, input logic [3:0] rt_i,
                           input logic [3:0] rd_i, input logic [7:0] rsd, input logic [7:0] rtd,
                           input logic [7:0] val, input logic imm, input logic sgn,
                           input logic rw, input logic rm, input logic wm, input logic [7:0] lbl);
    in_valid = 1'b1; opcode = op_i; rs = rs_i; rt = rt_i; rd = rd_i;
    rs_data = rsd; rt_data = rtd; value = val; imm_flag = imm; sign_flag = sgn;
    regwrite = rw; readmem = rm; writemem = wm; label_value = lbl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 0; stall = 0; flush = 0;
    set_instr(4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, alu_result, store_data, rd_out, writemem_out, readmem_out, regwrite_out,
         redirect, redirect_pc, halted} !== 41'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h exp 0", {out_valid, alu_result, store_data, rd_out,
        writemem_out, readmem_out, regwrite_out, redirect, redirect_pc, halted});
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_add();
    set_instr(4'h0, 4'd1, 4'd2, 4'd5, 8'hF0, 8'h20, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if ({out_valid, regwrite_out, alu_result, rd_out} !== {1'b1, 1'b1, 8'h10, 4'd5}) begin
      n_fail++; $display("FAIL add_wrap got v=%b rw=%b res=%h rd=%h exp v=1 rw=1 res=10 rd=5",
                         out_valid, regwrite_out, alu_result, rd_out);
    end
  endtask

  task automatic test_forwarding();
    set_instr(4'h0, 4'd1, 4'd2, 4'd3, 8'h04, 8'h05, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h09) begin n_fail++; $display("FAIL fwd_first got %h exp 09", alu_result); end
    set_instr(4'h1, 4'd3, 4'd4, 4'd6, 8'hAA, 8'h05, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h04) begin n_fail++; $display("FAIL fwd_sub got %h exp 04", alu_result); end
    set_instr(4'h0, 4'd1, 4'd2, 4'd0, 8'h04, 8'h05, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    set_instr(4'h1, 4'd0, 4'd4, 4'd6, 8'hAA, 8'h05, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'hA5) begin n_fail++; $display("FAIL no_fwd_r0 got %h exp a5", alu_result); end
    // rt forwarding from previous SUB (rd=6, result a5)
    set_instr(4'h4, 4'd1, 4'd6, 4'd7, 8'h0F, 8'h00, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'hAA) begin n_fail++; $display("FAIL fwd_rt_xor got %h exp aa", alu_result); end
  endtask

  task automatic test_alu_ops();
    set_instr(4'h7, 4'd1, 4'd2, 4'd8, 8'h80, 8'h01, 8'h00, 0, 1, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h01) begin n_fail++; $display("FAIL slt_signed got %h exp 01", alu_result); end
    set_instr(4'h7, 4'd1, 4'd2, 4'd8, 8'h80, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h00) begin n_fail++; $display("FAIL slt_unsigned got %h exp 00", alu_result); end
    set_instr(4'h5, 4'd1, 4'd2, 4'd9, 8'h81, 8'h00, 8'h0B, 1, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h08) begin n_fail++; $display("FAIL sll_imm got %h exp 08", alu_result); end
    set_instr(4'h6, 4'd1, 4'd2, 4'd9, 8'h81, 8'h03, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h10) begin n_fail++; $display("FAIL srl_reg got %h exp 10", alu_result); end
    set_instr(4'hD, 4'd1, 4'd2, 4'd9, 8'h81, 8'h03, 8'h5A, 1, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h5A) begin n_fail++; $display("FAIL mov_imm got %h exp 5a", alu_result); end
  endtask

  task automatic test_mem();
    set_instr(4'h8, 4'd1, 4'd2, 4'd10, 8'h10, 8'h00, 8'h05, 0, 0, 1, 1, 0, 8'h00);
    step();
    n_tests++;
    if ({alu_result, readmem_out, regwrite_out} !== {8'h15, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL lw_addr got res=%h rm=%b rw=%b exp 15 1 1", alu_result, readmem_out, regwrite_out);
    end
    // load result must not be forwarded
    set_instr(4'h0, 4'd10, 4'd2, 4'd11, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if (alu_result !== 8'h02) begin n_fail++; $display("FAIL no_fwd_load got %h exp 02", alu_result); end
    set_instr(4'h9, 4'd1, 4'd2, 4'd12, 8'h20, 8'h77, 8'h03, 0, 0, 1, 0, 1, 8'h00);
    step();
    n_tests++;
    if ({alu_result, store_data, writemem_out, regwrite_out} !== {8'h23, 8'h77, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw got res=%h sd=%h wm=%b rw=%b exp 23 77 1 0",
                         alu_result, store_data, writemem_out, regwrite_out);
    end
  endtask

  task automatic test_branch();
    set_instr(4'hA, 4'd1, 4'd2, 4'd13, 8'h11, 8'h11, 8'h00, 0, 0, 1, 0, 0, 8'h2C);
    step();
    n_tests++;
    if ({redirect, redirect_pc, regwrite_out, alu_result} !== {1'b1, 8'h2C, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL beq_taken got red=%b pc=%h rw=%b res=%h exp 1 2c 0 00",
                         redirect, redirect_pc, regwrite_out, alu_result);
    end
    stall = 1'b1;
    set_instr(4'h0, 4'd1, 4'd2, 4'd3, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if ({redirect, redirect_pc, alu_result} !== {1'b1, 8'h2C, 8'h00}) begin
      n_fail++; $display("FAIL beq_stall_hold got red=%b pc=%h res=%h exp 1 2c 00", redirect, redirect_pc, alu_result);
    end
    stall = 1'b0;
    step();
    n_tests++;
    if ({redirect, redirect_pc, alu_result} !== {1'b0, 8'h2C, 8'h02}) begin
      n_fail++; $display("FAIL redirect_clear got red=%b pc=%h res=%h exp 0 2c 02", redirect, redirect_pc, alu_result);
    end
    set_instr(4'hB, 4'd1, 4'd2, 4'd0, 8'h33, 8'h33, 8'h00, 0, 0, 0, 0, 0, 8'h40);
    step();
    n_tests++;
    if ({redirect, out_valid} !== 2'b01) begin
      n_fail++; $display("FAIL bne_not_taken got red=%b v=%b exp 0 1", redirect, out_valid);
    end
    set_instr(4'hC, 4'd1, 4'd2, 4'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h55);
    step();
    n_tests++;
    if ({redirect, redirect_pc} !== {1'b1, 8'h55}) begin
      n_fail++; $display("FAIL jmp got red=%b pc=%h exp 1 55", redirect, redirect_pc);
    end
  endtask

  task automatic test_bubbles();
    set_instr(4'h0, 4'd1, 4'd2, 4'd3, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    n_tests++;
    if ({out_valid, redirect, regwrite_out, redirect_pc} !== {1'b0, 1'b0, 1'b0, 8'h55}) begin
      n_fail++; $display("FAIL flush_bubble got v=%b red=%b rw=%b pc=%h exp 0 0 0 55",
                         out_valid, redirect, regwrite_out, redirect_pc);
    end
    set_instr(4'hE, 4'd1, 4'd2, 4'd3, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if ({out_valid, regwrite_out} !== 2'b00) begin
      n_fail++; $display("FAIL nop_bubble got v=%b rw=%b exp 0 0", out_valid, regwrite_out);
    end
  endtask

  task automatic test_halt();
    set_instr(4'hF, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_tests++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_flushed got %b exp 0", halted); end
    stall = 1'b1;
    step();
    n_tests++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_stalled got %b exp 0", halted); end
    stall = 1'b0;
    step();
    n_tests++;
    if ({halted, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL halt_retire got h=%b v=%b exp 1 0", halted, out_valid);
    end
    set_instr(4'h0, 4'd1, 4'd2, 4'd3, 8'h01, 8'h01, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if ({halted, out_valid, regwrite_out} !== 3'b100) begin
      n_fail++; $display("FAIL halted_ignores got h=%b v=%b rw=%b exp 1 0 0", halted, out_valid, regwrite_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, alu_result, redirect_pc, halted} !== 18'd0) begin
      n_fail++; $display("FAIL async_reset got v=%b res=%h pc=%h h=%b exp all 0", out_valid, alu_result, redirect_pc, halted);
    end
    @(negedge clk) rst_n = 1'b1;
    set_instr(4'h0, 4'd1, 4'd2, 4'd3, 8'h01, 8'h02, 8'h00, 0, 0, 1, 0, 0, 8'h00);
    step();
    n_tests++;
    if ({out_valid, alu_result, halted} !== {1'b1, 8'h03, 1'b0}) begin
      n_fail++; $display("FAIL run_after_reset got v=%b res=%h h=%b exp 1 03 0", out_valid, alu_result, halted);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_alu_ops();
    test_mem();
    test_branch();
    test_bubbles();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
